// File: rtl/ddr4_cmd_pkg.sv
// DDR4 command encodings and refresh FSM state type shared by the refresh path.
// Command bits sit on A[16:14] as {RAS_n, CAS_n, WE_n}; A[0] selects per-bank refresh.
package ddr4_cmd_pkg;

  localparam int CMD_AW = 17;

  localparam logic [CMD_AW-1:0] REF_CODE = 17'h04001;
  localparam logic [CMD_AW-1:0] ACT_CODE = 17'h00000;
  localparam logic [CMD_AW-1:0] PRE_CODE = 17'h08000;
  localparam logic [CMD_AW-1:0] RD_CODE  = 17'h14000;
  localparam logic [CMD_AW-1:0] WR_CODE  = 17'h10000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ISSUE = 2'd2,
    GAP   = 2'd3
  } ref_state_e;

endpackage

// File: rtl/refi_timer.sv
// Free-running refresh interval counter; tick_o marks the TINT-1 -> 0 wrap.
module refi_timer #(
  parameter int TINT = 650
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int CW = (TINT > 1) ? $clog2(TINT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TINT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: hold while disabled, wrap after the last interval cycle.
  always_comb begin
    tick_o = enable_i && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (!enable_i) begin
      cnt_d = cnt_q;
    end else if (tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/refresh_interleaver.sv
// Per-bank DDR4 refresh scheduler: walks banks ba-fastest, requests a command
// slot from the arbiter and emits registered REF commands; tracks postponed refreshes.
module refresh_interleaver
  import ddr4_cmd_pkg::*;
#(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int TREFI     = 10400,
  parameter int MAXPEND   = 8,
  parameter int TGAP      = 0
) (
  input  logic                                 ck_t,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic [2**(BGWIDTH+BAWIDTH)-1:0]      bank_open,
  input  logic                                 ref_gnt,
  output logic                                 ref_req,
  output logic                                 ref_urgent,
  output logic                                 ref_overflow,
  output logic [$clog2(MAXPEND+1)-1:0]         pending,
  output logic                                 cmd_valid,
  output logic                                 cs_n,
  output logic                                 act_n,
  output logic [ADDRWIDTH-1:0]                 A,
  output logic [BGWIDTH-1:0]                   bg,
  output logic [BAWIDTH-1:0]                   ba
);

  localparam int PTRW  = BGWIDTH + BAWIDTH;
  localparam int BANKS = 2**PTRW;
  localparam int TINT  = TREFI / BANKS;
  localparam int PW    = $clog2(MAXPEND + 1);
  localparam int GW    = (TGAP > 1) ? $clog2(TGAP) : 1;
  localparam logic [PW-1:0] PEND_MAX = PW'(MAXPEND);
  localparam logic [GW-1:0] GAP_LAST = GW'((TGAP > 0) ? (TGAP - 1) : 0);

  ref_state_e           state_q, state_d;
  logic [PTRW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]        pend_q, pend_d;
  logic                 ovf_q, ovf_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 req_q, req_d;
  logic                 valid_q, valid_d;
  logic                 csn_q, csn_d;
  logic [ADDRWIDTH-1:0] a_q, a_d;
  logic [BGWIDTH-1:0]   bg_q, bg_d;
  logic [BAWIDTH-1:0]   ba_q, ba_d;
  logic                 tick;
  logic                 issuing;

  refi_timer #(.TINT(TINT)) u_timer (
    .clk_i    (ck_t),
    .reset_i  (reset),
    .enable_i (enable),
    .tick_o   (tick)
  );

  assign issuing = (state_q == ISSUE);

  // FSM next state; a busy target bank or disable withdraws an outstanding request.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if ((pend_q != '0) && !bank_open[ptr_q] && enable) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bank_open[ptr_q] || !enable) begin
          state_d = IDLE;
        end else if (ref_gnt) begin
          state_d = ISSUE;
        end else begin
          state_d = REQ;
        end
      end
      ISSUE: begin
        gap_d = '0;
        if (TGAP > 0) begin
          state_d = GAP;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pending count, overflow flag and bank pointer.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    ptr_d  = ptr_q;
    if (tick && !issuing) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PW'(1);
      end
    end else if (!tick && issuing && (pend_q != '0)) begin
      pend_d = pend_q - PW'(1);
    end else begin
      pend_d = pend_q;
    end
    if (issuing) begin
      ptr_d = ptr_q + PTRW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Command outputs are registered from the next state so they align with it.
  always_comb begin
    req_d   = (state_d == REQ);
    valid_d = (state_d == ISSUE);
    csn_d   = 1'b1;
    a_d     = '0;
    bg_d    = bg_q;
    ba_d    = ba_q;
    if (state_d == ISSUE) begin
      csn_d = 1'b0;
      a_d   = ADDRWIDTH'(REF_CODE);
      bg_d  = ptr_q[PTRW-1:BAWIDTH];
      ba_d  = ptr_q[BAWIDTH-1:0];
    end else begin
      csn_d = 1'b1;
    end
  end

  always_ff @(posedge ck_t) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      gap_q   <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      csn_q   <= 1'b1;
      a_q     <= '0;
      bg_q    <= '0;
      ba_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      gap_q   <= gap_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      csn_q   <= csn_d;
      a_q     <= a_d;
      bg_q    <= bg_d;
      ba_q    <= ba_d;
    end
  end

  assign ref_req      = req_q;
  assign ref_urgent   = (pend_q == PEND_MAX);
  assign ref_overflow = ovf_q;
  assign pending      = pend_q;
  assign cmd_valid    = valid_q;
  assign cs_n         = csn_q;
  assign act_n        = 1'b1;
  assign A            = a_q;
  assign bg           = bg_q;
  assign ba           = ba_q;

endmodule

// File: doc/refresh_interleaver.md
Name: refresh_interleaver

Overview:
- Per-bank refresh scheduler sitting directly upstream of the dimm model's command port, on the arbitrated command path.
- Generates DDR4 per-bank REF commands and walks all bank groups/banks in interleaved order (ba fastest, then bg), one bank every TREFI/BANKS cycles.
- Requests command-bus slots from the command arbiter via a req/gnt handshake.
- Tracks postponed refreshes and flags urgency/overflow.

Parameters:
- BGWIDTH, 2, bank-group address width
- BAWIDTH, 2, bank address width
- ADDRWIDTH, 17, command address width (A)
- TREFI, 10400, cycles per full all-bank refresh round (7.8 us at tCK 0.75 ns); must be a multiple of BANKS
- MAXPEND, 8, max postponed per-bank refreshes (DDR4 postpone limit)
- TGAP, 0, extra idle cycles after each issued REF before the next request
- Derived localparams: BANKS = 2**(BGWIDTH+BAWIDTH); TINT = TREFI/BANKS; PW = $clog2(MAXPEND+1)

Ports:
- ck_t  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  refresh engine enable; low freezes the interval timer
- bank_open  in  BANKS  per-bank open-row flags, index = {bg,ba}; a bank must be closed before REF
- ref_gnt  in  1  arbiter grant; sampled only while ref_req=1
- ref_req  out  1  request for a command slot
- ref_urgent  out  1  pending == MAXPEND
- ref_overflow  out  1  sticky; set when an interval tick arrives with pending == MAXPEND
- pending  out  PW  postponed refresh count
- cmd_valid  out  1  high in the REF command cycle
- cs_n  out  1  chip select, active low
- act_n  out  1  activate, held 1 for REF
- A  out  ADDRWIDTH  command address
- bg  out  BGWIDTH  bank group of the issued REF
- ba  out  BAWIDTH  bank of the issued REF

Behaviour:
- Reset values (registered, effective in the cycle after reset is sampled high; overrides everything mid-operation):
  - ref_req=0, ref_urgent=0, ref_overflow=0, pending=0, cmd_valid=0
  - cs_n=1, act_n=1, A=0, bg=0, ba=0
  - internal timer=0, bank pointer=0, FSM=IDLE
- Interval timer:
  - Counts 0..TINT-1 while enable=1 and holds while enable=0.
  - A tick occurs on the wrap from TINT-1 to 0.
  - A tick increments pending, saturating at MAXPEND. A tick at saturation sets ref_overflow instead; overflow clears only on reset.
- Tick and issue in the same cycle (tick coinciding with the ISSUE cycle): pending is unchanged.
- FSM states: IDLE, REQ, ISSUE, GAP.
  - IDLE -> REQ when pending>0 and bank_open[ptr]=0 and enable=1.
  - REQ: ref_req=1. On ref_gnt=1, go to ISSUE.
  - REQ: if bank_open[ptr] rises before grant, drop ref_req and return to IDLE.
  - REQ -> IDLE if enable falls before grant.
  - ISSUE, a single cycle:
    - cmd_valid=1, cs_n=0, act_n=1, bg/ba = pointer.
    - A = REF_CODE: A[16:14]=3'b001 (RAS=0, CAS=0, WE=1), A[0]=1 (per-bank select), all other bits 0, i.e. 17'h04001.
    - pending decrements; pointer increments.
  - ISSUE -> GAP if TGAP>0, otherwise -> IDLE.
  - GAP counts TGAP cycles, then -> IDLE.
  - Outside ISSUE, cs_n=1, act_n=1, A=0, cmd_valid=0; bg/ba hold their last issued values.
- Latency:
  - grant sampled in cycle N gives the command in cycle N+1.
  - minimum REF-to-REF spacing is 3+TGAP cycles (ISSUE, IDLE, REQ-with-grant).
- Pointer is a BGWIDTH+BAWIDTH counter, split as {bg,ba}. Order is (0,0),(0,1)...(0,3),(1,0)...(3,3), then wraps to (0,0). The pointer never skips a bank; a busy bank blocks progress.
- ref_urgent is combinational on pending == MAXPEND. The arbiter uses it to force precharge and grant.
- An enable drop during ISSUE/GAP lets the command complete; pending is retained.

Decomposition:
- ddr4_cmd_pkg:
  - REF_CODE and other DDR4 command encodings (ACT, PRE, RD, WR) as ADDRWIDTH-wide constants
  - state typedef enum {IDLE, REQ, ISSUE, GAP}
- Sub-module refi_timer: interval counter with enable and a tick output (reused by the all-bank refresh path).
- FSM, pending counter and pointer live in the top.

Test Plan:
- Reset: hold reset 3 cycles while forcing ref_gnt=1 -> cs_n=1, act_n=1, A=0, ref_req=0, pending=0 throughout and one cycle after release.
- Round-robin: TREFI=64 (TINT=4), ref_gnt=1, bank_open=0, enable=1 for 70 cycles -> REF cmd_valid every 4 cycles with A=17'h04001; (bg,ba) sequence (0,0)..(3,3) then (0,0) again; pending never exceeds 1.
- Postpone/saturate: TINT=4, ref_gnt=0 for 40 cycles -> pending reaches 8, ref_urgent=1, ref_overflow=1 after the 9th tick. Then ref_gnt=1 -> 8 REFs spaced 3 cycles apart; pending returns to 0 (minus ticks during drain); ref_overflow stays 1.
- Busy bank: pending=1, bank_open[0]=1 for 20 cycles -> ref_req=0, no command. Clear bank_open[0] -> REQ next cycle; REF to (0,0) the cycle after grant.
- Simultaneous tick and issue: align the ISSUE cycle with a timer wrap at pending=2 -> pending stays 2 in the next cycle.
- Reset mid-operation: assert reset in the ISSUE cycle -> next cycle cs_n=1, cmd_valid=0, pending=0, ptr=(0,0), ref_overflow=0.
